// File: rtl/systolic_array_ctrl_if.sv
// Control and handshake bundle between the DRAM fetch engine and the
// systolic array sequencer.
//   master : fetch-engine side; drives start/num_act/abort/in_valid and
//            observes the array controls and status.
//   slave  : sequencer side; the mirror image of master.
interface systolic_array_ctrl_if #(
  parameter int unsigned LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] num_act;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op_code;
  logic             weight_or_act;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, num_act, abort, in_valid,
    input  in_ready, op_code, weight_or_act, out_valid, busy, done
  );

  modport slave (
    input  start, num_act, abort, in_valid,
    output in_ready, op_code, weight_or_act, out_valid, busy, done
  );
endinterface

// File: rtl/systolic_array_ctrl.sv
// Job sequencer for a PE_X x PE_Y weight-stationary systolic array.
// A job is PE_Y weight beats, num_act activation beats, then LAT drain cycles.
// Outputs are a combinational decode of the registered state, the counters
// and the result valid pipe.
// Ports:
//   clk    : clock
//   reset  : asynchronous active-low reset
//   bus    : slave side of systolic_array_ctrl_if (start/num_act/abort,
//            in_valid/in_ready beat handshake, op_code, weight_or_act,
//            out_valid, busy, done)
module systolic_array_ctrl #(
  parameter int unsigned BITWIDTH = 16,
  parameter int unsigned PE_X     = 4,
  parameter int unsigned PE_Y     = 4,
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned LAT      = PE_X + PE_Y
) (
  input logic                  clk,
  input logic                  reset,
  systolic_array_ctrl_if.slave bus
);

  localparam int unsigned WCNT_W = $clog2(PE_Y + 1);
  localparam int unsigned DCNT_W = $clog2(LAT + 1);

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_LOAD_W = 3'b001;
  localparam logic [2:0] OP_MAC    = 3'b010;
  localparam logic [2:0] OP_DRAIN  = 3'b011;

  // Elaboration guard: the valid pipe shift needs at least two stages.
  if (BITWIDTH < 1 || PE_X < 1 || PE_Y < 1 || LAT < 2) begin : g_param_check
    $error("systolic_array_ctrl: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [LEN_W-1:0]    r_num_act;
  logic [WCNT_W-1:0]   r_wcnt;
  logic [LEN_W-1:0]    r_acnt;
  logic [DCNT_W-1:0]   r_dcnt;
  logic [LAT-1:0]      r_pipe;

  logic                w_in_ready;
  logic [2:0]          w_op;
  logic                w_woa;
  logic                w_busy;
  logic                w_done;
  logic                w_abort;
  logic                w_last_w;
  logic                w_last_a;
  logic                w_last_d;
  logic                w_adv;
  logic                w_mac;

  // Phase-end detects; counters hold the number of beats/cycles already seen.
  assign w_last_w = (r_wcnt == WCNT_W'(PE_Y - 1));
  assign w_last_a = (r_acnt == (r_num_act - LEN_W'(1)));
  assign w_last_d = (r_dcnt == DCNT_W'(LAT - 1));
  assign w_abort  = bus.abort && (r_state != S_IDLE);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and output decode.
  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_op       = OP_NOP;
    w_woa      = 1'b0;
    w_busy     = 1'b1;
    w_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) w_next = S_LOAD_W;
      end
      S_LOAD_W: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_op = OP_LOAD_W;
          if (w_last_w) w_next = (r_num_act != '0) ? S_COMPUTE : S_DONE;
        end
      end
      S_COMPUTE: begin
        w_in_ready = 1'b1;
        w_woa      = 1'b1;
        if (bus.in_valid) begin
          w_op = OP_MAC;
          if (w_last_a) w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_op = OP_DRAIN;
        if (w_last_d) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_busy = 1'b0;
        w_next = S_IDLE;
      end
    endcase
    // Abort only redirects the next state; this cycle's decode stands.
    if (w_abort) w_next = S_IDLE;
  end

  // Only MAC and DRAIN cycles move data through the PEs.
  assign w_mac = (w_op == OP_MAC);
  assign w_adv = w_mac || (w_op == OP_DRAIN);

  // Job length latch, phase counters and result valid pipe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_num_act <= '0;
      r_wcnt    <= '0;
      r_acnt    <= '0;
      r_dcnt    <= '0;
      r_pipe    <= '0;
    end else begin
      if (r_state == S_IDLE && bus.start) r_num_act <= bus.num_act;

      if (r_state != S_LOAD_W)  r_wcnt <= '0;
      else if (w_op == OP_LOAD_W) r_wcnt <= r_wcnt + WCNT_W'(1);

      if (r_state != S_COMPUTE) r_acnt <= '0;
      else if (w_mac)           r_acnt <= r_acnt + LEN_W'(1);

      if (r_state != S_DRAIN)   r_dcnt <= '0;
      else                      r_dcnt <= r_dcnt + DCNT_W'(1);

      // Bit k marks a MAC beat that has seen k+1 advancing cycles.
      if (w_abort)    r_pipe <= '0;
      else if (w_adv) r_pipe <= {r_pipe[LAT-2:0], w_mac};
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.op_code       = w_op;
  assign bus.weight_or_act = w_woa;
  assign bus.busy          = w_busy;
  assign bus.done          = w_done;
  assign bus.out_valid     = w_adv && r_pipe[LAT-1];

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Self-checking bench for systolic_array_ctrl: directed job timelines plus
// randomized traffic compared cycle by cycle against a behavioural model.
module tb_systolic_array_ctrl;
  localparam int unsigned PE_X  = 4;
  localparam int unsigned PE_Y  = 4;
  localparam int unsigned LEN_W = 8;
  localparam int unsigned LAT   = PE_X + PE_Y;

  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_COMP  = 2;
  localparam int P_DRAIN = 3;
  localparam int P_DONE  = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  systolic_array_ctrl_if #(.LEN_W(LEN_W)) bus ();

  systolic_array_ctrl #(
    .BITWIDTH(16), .PE_X(PE_X), .PE_Y(PE_Y), .LEN_W(LEN_W), .LAT(LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model state: job phase, beats/cycles left in it, advancing-cycle index,
  // and the advancing-cycle indices at which results are due.
  int m_phase;
  int m_left;
  int m_num;
  int m_adv;
  int m_due[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE;
    m_left  = 0;
    m_num   = 0;
    m_adv   = 0;
    m_due.delete();
  endtask

  task automatic check_all_zero(input string ctx);
    check({ctx, ".in_ready"},  32'(bus.in_ready), 0);
    check({ctx, ".op_code"},   32'(bus.op_code), 0);
    check({ctx, ".woa"},       32'(bus.weight_or_act), 0);
    check({ctx, ".out_valid"}, 32'(bus.out_valid), 0);
    check({ctx, ".busy"},      32'(bus.busy), 0);
    check({ctx, ".done"},      32'(bus.done), 0);
  endtask

  // One clock cycle: drive, compare against the model mid-cycle, advance model.
  task automatic cycle(input bit st, input int num, input bit ab, input bit iv,
                       output bit ov, output bit dn);
    int e_rdy, e_op, e_woa, e_busy, e_done, e_ov;
    bus.start    = st;
    bus.num_act  = LEN_W'(num);
    bus.abort    = ab;
    bus.in_valid = iv;
    @(negedge clk);
    e_rdy = 0; e_op = 0; e_woa = 0; e_busy = (m_phase != P_IDLE); e_done = 0; e_ov = 0;
    case (m_phase)
      P_LOAD:  begin e_rdy = 1; e_op = iv ? 1 : 0; end
      P_COMP:  begin e_rdy = 1; e_woa = 1; e_op = iv ? 2 : 0; end
      P_DRAIN: e_op = 3;
      P_DONE:  e_done = 1;
      default: ;
    endcase
    if (e_op == 2 || e_op == 3) begin
      m_adv++;
      if (m_due.size() > 0 && m_due[0] == m_adv) begin
        e_ov = 1;
        void'(m_due.pop_front());
      end
      if (e_op == 2) m_due.push_back(m_adv + LAT);
    end
    check("in_ready",  32'(bus.in_ready), e_rdy);
    check("op_code",   32'(bus.op_code), e_op);
    check("woa",       32'(bus.weight_or_act), e_woa);
    check("busy",      32'(bus.busy), e_busy);
    check("done",      32'(bus.done), e_done);
    check("out_valid", 32'(bus.out_valid), e_ov);
    ov = bus.out_valid;
    dn = bus.done;
    if (m_phase != P_IDLE && ab) begin
      m_phase = P_IDLE;
      m_due.delete();
    end else begin
      case (m_phase)
        P_IDLE: if (st) begin m_num = num; m_phase = P_LOAD; m_left = PE_Y; end
        P_LOAD: if (iv) begin
          m_left--;
          if (m_left == 0) begin
            if (m_num > 0) begin m_phase = P_COMP; m_left = m_num; end
            else m_phase = P_DONE;
          end
        end
        P_COMP: if (iv) begin
          m_left--;
          if (m_left == 0) begin m_phase = P_DRAIN; m_left = LAT; end
        end
        P_DRAIN: begin
          m_left--;
          if (m_left == 0) m_phase = P_DONE;
        end
        default: m_phase = P_IDLE;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  // Job starting at relative cycle 0; negative indices disable a feature.
  task automatic directed(input int num, input int stall_lo, input int stall_hi,
                          input int abort_at, input int restart_at, input int ncyc,
                          output int first_ov, output int done_at, output int ov_cnt);
    first_ov = -1; done_at = -1; ov_cnt = 0;
    for (int c = 0; c < ncyc; c++) begin
      bit ov, dn;
      cycle(c == 0 || c == restart_at, num, c == abort_at,
            !(c >= stall_lo && c <= stall_hi), ov, dn);
      if (ov) begin
        ov_cnt++;
        if (first_ov < 0) first_ov = c;
      end
      if (dn && done_at < 0) done_at = c;
    end
  endtask

  initial begin
    int fo, da, oc;
    bit ov, dn;
    model_reset();

    // Reset held with live inputs: everything quiet.
    reset = 1'b0;
    bus.start = 1'b1; bus.num_act = 8'd5; bus.abort = 1'b0; bus.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("rst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b0, 1'b1, ov, dn);

    // Basic job, num_act=3.
    directed(3, -1, -1, -1, -1, 18, fo, da, oc);
    check("basic.first_ov", fo, 13);
    check("basic.done_at",  da, 16);
    check("basic.ov_cnt",   oc, 3);

    // Stall in COMPUTE at cycles 6-7.
    directed(3, 6, 7, -1, -1, 20, fo, da, oc);
    check("stall.first_ov", fo, 15);
    check("stall.done_at",  da, 18);
    check("stall.ov_cnt",   oc, 3);

    // Zero activations.
    directed(0, -1, -1, -1, -1, 8, fo, da, oc);
    check("zero.done_at", da, 5);
    check("zero.ov_cnt",  oc, 0);

    // Abort at cycle 6, then a fresh job right after.
    directed(3, -1, -1, 6, -1, 8, fo, da, oc);
    check("abort.done_at", da, -1);
    check("abort.ov_cnt",  oc, 0);
    directed(3, -1, -1, -1, -1, 18, fo, da, oc);
    check("after_abort.first_ov", fo, 13);
    check("after_abort.done_at",  da, 16);
    check("after_abort.ov_cnt",   oc, 3);

    // Maximum activation count.
    directed(255, -1, -1, -1, -1, 270, fo, da, oc);
    check("max.first_ov", fo, 13);
    check("max.done_at",  da, 268);
    check("max.ov_cnt",   oc, 255);

    // Ignored start at cycle 9, then asynchronous reset in cycle 11 mid-DRAIN.
    directed(3, -1, -1, -1, 9, 11, fo, da, oc);
    bus.start = 1'b0; bus.abort = 1'b0; bus.in_valid = 1'b1;
    @(negedge clk);
    check("pre_rst.op_code", 32'(bus.op_code), 3);
    check("pre_rst.busy",    32'(bus.busy), 1);
    reset = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    check_all_zero("async_rst_hold");
    reset = 1'b1;
    model_reset();
    cycle(1'b0, 0, 1'b0, 1'b1, ov, dn);
    directed(2, -1, -1, -1, -1, 17, fo, da, oc);
    check("post_rst.first_ov", fo, 13);
    check("post_rst.done_at",  da, 15);
    check("post_rst.ov_cnt",   oc, 2);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      bit st, ab, iv;
      int num;
      st  = ($urandom_range(0, 3) == 0);
      num = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 5));
      ab  = ($urandom_range(0, 99) == 0);
      iv  = ($urandom_range(0, 9) < 7);
      cycle(st, num, ab, iv, ov, dn);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/systolic_array_ctrl.md
Name: systolic_array_ctrl

Overview:
Sequencer for the PE_X x PE_Y weight-stationary systolic array. On a start command it steers one DRAM input stream through three phases: weight load, activation streaming and pipeline drain. It drives the array's op_code and weight_or_act controls, gates data beats with a valid/ready handshake, and flags which accel_output_data cycles carry results. It sits between the DRAM fetch engine and the array top.

Parameters:
BITWIDTH, 16, element width in bits
PE_X, 4, array columns
PE_Y, 4, array rows; also the number of weight beats per job
LEN_W, 8, width of the activation-count field
LAT, PE_X+PE_Y, advancing cycles from an accepted MAC beat to its result on accel_output_data

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  job start pulse; accepted only in IDLE
num_act  in  LEN_W  activation beats for the job; sampled when start is accepted
abort  in  1  synchronous job cancel
in_valid  in  1  DRAM beat present on accel_input_data
in_ready  out  1  controller accepts the beat this cycle
op_code  out  3  array opcode: 000 NOP, 001 LOAD_W, 010 MAC, 011 DRAIN
weight_or_act  out  1  0 = beat is weight, 1 = beat is activation
out_valid  out  1  accel_output_data holds a valid result row this cycle
busy  out  1  high in every state except IDLE
done  out  1  one-cycle job-complete pulse

Behaviour:
- Reset is asynchronous while reset=0. All outputs go to 0 immediately, state returns to IDLE, and all counters and the valid pipe clear.
- State encoding: IDLE, LOAD_W, COMPUTE, DRAIN, DONE.
- All outputs are a registered state plus combinational decode. A beat is accepted when in_valid & in_ready.
- IDLE:
  - in_ready=0, op_code=NOP.
  - start=1 latches num_act and moves to LOAD_W.
- LOAD_W:
  - in_ready=1, weight_or_act=0.
  - op_code=LOAD_W on an accepted beat, NOP otherwise.
  - After PE_Y accepted beats: go to COMPUTE if the latched num_act>0, else go to DONE.
- COMPUTE:
  - in_ready=1, weight_or_act=1.
  - op_code=MAC on an accepted beat, NOP otherwise.
  - After num_act accepted beats, go to DRAIN.
- DRAIN:
  - in_ready=0, op_code=DRAIN.
  - Lasts exactly LAT cycles, then goes to DONE.
- DONE: done=1 for one cycle, busy=1, then IDLE.
- Stall rule: PEs hold state on NOP. An "advancing cycle" is any cycle with op_code MAC or DRAIN.
- Result tracking:
  - Each MAC beat enters a LAT-deep valid pipe. The pipe shifts only on advancing cycles.
  - out_valid=1 on the advancing cycle that is the LAT-th advancing cycle after that MAC beat.
  - Exactly num_act out_valid cycles occur per job. The final one lands on the last DRAIN cycle.
- Counters:
  - The weight counter is clog2(PE_Y+1) bits; the activation counter is LEN_W bits. Neither wraps within a job.
  - num_act = 2^LEN_W-1 is legal.
- start while busy is ignored; num_act is not re-sampled.
- abort=1 in any busy state:
  - Next state is IDLE and the valid pipe clears.
  - done is not pulsed, and in_ready/op_code go inactive on the following cycle.
  - abort in IDLE has no effect.
  - abort and start together in IDLE: start wins.
- in_valid is ignored in IDLE, DRAIN and DONE. Beats offered there are not consumed.
- There is no backpressure on results: the consumer must take every out_valid row.

Test Plan:
1. Reset: hold reset=0 with in_valid=1 and start=1 → all outputs 0, busy=0; after release, the state is IDLE.
2. Basic job (PE_X=PE_Y=4, LAT=8): start at cycle 0 with num_act=3 and in_valid held 1 → LOAD_W cycles 1-4 (op_code=001), MAC cycles 5-7, DRAIN cycles 8-15, out_valid at cycles 13,14,15, done at cycle 16.
3. Stall: same job with in_valid=0 at cycles 6-7 → op_code=NOP at 6-7, MAC at 5,8,9, DRAIN 10-17, out_valid at 15,16,17, done at 18.
4. Zero activations: start with num_act=0 → 4 LOAD_W beats, done at cycle 5, out_valid never asserts, op_code never MAC/DRAIN.
5. Abort: abort=1 at cycle 6 of test 2 → IDLE at cycle 7, busy=0, no done, no out_valid afterwards; a new start at cycle 8 runs cleanly from LOAD_W.
6. Mid-job reset and ignored start: pulse start at cycle 9 of test 2 → no effect. Then drive reset=0 asynchronously at cycle 11.5 → outputs 0 before the next clk edge; after release, the controller is IDLE with the valid pipe empty.
